// File: rtl/keypad_pkg.sv
// Shared types and constant tables for the keypad history display.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the scan FSM state enum, the 4x4 keypad legend and the active-low
// seven-segment glyph table (bit 0 = segment a ... bit 6 = segment g).
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_HELD,
      ST_REL_DB
   } kp_state_t;

   // Standard telephone-style 4x4 pad: '*' reports as E, '#' as F.
   // Index is row*4 + col, row 0 at the top.
   localparam logic [0:15][3:0] KEYMAP = {
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hE, 4'h0, 4'hF, 4'hD
   };

   // Active-low glyphs, {g,f,e,d,c,b,a}; b and d are lower-case.
   localparam logic [0:15][6:0] SEG_TABLE = {
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low seven-segment pattern.
// Latency: combinational.
// Backpressure: none.
//
// Ports: hex  - 4-bit value to display
//        seg  - segments a..g (bit 0 = a), active-low
module hex7seg
   import keypad_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/keypad_history_display.sv
// Scanned-matrix keypad with debounce, press history and multiplexed 7-seg display.
// Latency: cols -> decision 2 clk sync, press accepted after DB_TICKS stable scan ticks.
// Backpressure: none; a held key blocks scanning until released (no auto-repeat).
//
// Ports: clk, reset (async, active-low)
//        cols       - keypad columns, active-low, asynchronous
//        rows       - one-cold row drive
//        seg, anode - registered display outputs, active-low
//        key_valid  - one-clk pulse per accepted press; key_code holds its code
module keypad_history_display
   import keypad_pkg::*;
#(
   parameter int          NROWS      = 4,
   parameter int          NCOLS      = 4,
   parameter int          NDIG       = 2,
   parameter int          SCAN_DIV   = 60000,
   parameter int          DB_TICKS   = 4,
   parameter int          MUX_DIV    = 30000,
   parameter int          CLEAR_EN   = 0,
   parameter logic [3:0]  CLEAR_CODE = 4'hE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NCOLS-1:0] cols,
   output logic [NROWS-1:0] rows,
   output logic [6:0]       seg,
   output logic [NDIG-1:0]  anode,
   output logic             key_valid,
   output logic [3:0]       key_code
);

   localparam int RW = $clog2(NROWS);
   localparam int CW = $clog2(NCOLS);
   localparam int SW = $clog2(SCAN_DIV + 1);
   localparam int DW = $clog2(DB_TICKS + 1);
   localparam int MW = $clog2(MUX_DIV + 1);
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

   logic [NCOLS-1:0] cols_m, cols_s;
   logic [SW-1:0]    sc_cnt;
   logic             tick;
   kp_state_t        state_q, state_d;
   logic [RW-1:0]    row_q, row_d, row_next;
   logic [CW-1:0]    col_q, col_d, low_col;
   logic [DW-1:0]    cnt_q, cnt_d;
   logic             any_low;
   logic             pulse_d;
   logic [3:0]       code_d;
   logic [3:0]       hist [NDIG];
   logic [MW-1:0]    mx_cnt;
   logic [IW-1:0]    idx_q;
   logic [NDIG-1:0]  anode_d;
   logic [6:0]       dec_seg;

   // 4x4 pads use the printed legend; other sizes number keys linearly.
   function automatic logic [3:0] key_of(input logic [RW-1:0] r, input logic [CW-1:0] c);
      int lin;
      lin = int'(r) * NCOLS + int'(c);
      if (NROWS == 4 && NCOLS == 4) return KEYMAP[lin[3:0]];
      return lin[3:0];
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cols_m <= '1;
         cols_s <= '1;
      end else begin
         cols_m <= cols;
         cols_s <= cols_m;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                         sc_cnt <= '0;
      else if (sc_cnt == SW'(SCAN_DIV-1)) sc_cnt <= '0;
      else                                sc_cnt <= sc_cnt + SW'(1);
   end
   assign tick = (sc_cnt == SW'(SCAN_DIV-1));

   // Lowest-index active column wins when several keys share the row.
   always_comb begin
      any_low = 1'b0;
      low_col = '0;
      for (int i = NCOLS-1; i >= 0; i--) begin
         if (!cols_s[i]) begin
            any_low = 1'b1;
            low_col = CW'(i);
         end
      end
   end

   assign row_next = (row_q == RW'(NROWS-1)) ? '0 : row_q + RW'(1);

   always_comb begin
      rows         = '1;
      rows[row_q]  = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_SCAN;
         row_q     <= '0;
         col_q     <= '0;
         cnt_q     <= '0;
         key_valid <= 1'b0;
         key_code  <= '0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         col_q     <= col_d;
         cnt_q     <= cnt_d;
         key_valid <= pulse_d;
         key_code  <= code_d;
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      code_d  = key_code;
      if (tick) begin
         case (state_q)
            ST_SCAN: begin
               if (any_low) begin
                  col_d   = low_col;
                  cnt_d   = '0;
                  state_d = ST_DEBOUNCE;
               end else begin
                  row_d = row_next;
               end
            end
            ST_DEBOUNCE: begin
               if (!cols_s[col_q]) begin
                  if (cnt_q == DW'(DB_TICKS-1)) begin
                     pulse_d = 1'b1;
                     code_d  = key_of(row_q, col_q);
                     cnt_d   = '0;
                     state_d = ST_HELD;
                  end else begin
                     cnt_d = cnt_q + DW'(1);
                  end
               end else begin
                  // Bounce: rescan the same row from scratch.
                  state_d = ST_SCAN;
               end
            end
            ST_HELD: begin
               if (cols_s[col_q]) begin
                  cnt_d   = '0;
                  state_d = ST_REL_DB;
               end
            end
            ST_REL_DB: begin
               if (!cols_s[col_q]) begin
                  // Release bounce returns to HELD silently: no repeat press.
                  state_d = ST_HELD;
               end else if (cnt_q == DW'(DB_TICKS-1)) begin
                  cnt_d   = '0;
                  row_d   = row_next;
                  state_d = ST_SCAN;
               end else begin
                  cnt_d = cnt_q + DW'(1);
               end
            end
            default: state_d = ST_SCAN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NDIG; i++) hist[i] <= '0;
      end else if (pulse_d) begin
         if (CLEAR_EN != 0 && code_d == CLEAR_CODE) begin
            for (int i = 0; i < NDIG; i++) hist[i] <= '0;
         end else begin
            hist[0] <= code_d;
            for (int i = 1; i < NDIG; i++) hist[i] <= hist[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mx_cnt <= '0;
         idx_q  <= '0;
      end else if (mx_cnt == MW'(MUX_DIV-1)) begin
         mx_cnt <= '0;
         idx_q  <= (idx_q == IW'(NDIG-1)) ? '0 : idx_q + IW'(1);
      end else begin
         mx_cnt <= mx_cnt + MW'(1);
      end
   end

   always_comb begin
      anode_d        = '1;
      anode_d[idx_q] = 1'b0;
   end

   hex7seg u_hex7seg (
      .hex (hist[idx_q]),
      .seg (dec_seg)
   );

   // Both display outputs come from one register stage off the same index,
   // so digit select and segment pattern always switch together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         anode <= '1;
         seg   <= 7'h7F;
      end else begin
         anode <= anode_d;
         seg   <= dec_seg;
      end
   end

endmodule

// File: tb/tb_keypad_history_display.sv
module tb_keypad_history_display;

   localparam int         NROWS      = 4;
   localparam int         NCOLS      = 4;
   localparam int         NDIG       = 2;
   localparam int         SCAN_DIV   = 4;
   localparam int         DB_TICKS   = 3;
   localparam int         MUX_DIV    = 8;
   localparam int         CLEAR_EN   = 1;
   localparam logic [3:0] CLEAR_CODE = 4'hE;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [NCOLS-1:0] cols;
   logic [NROWS-1:0] rows;
   logic [6:0]       seg;
   logic [NDIG-1:0]  anode;
   logic             key_valid;
   logic [3:0]       key_code;

   logic [NROWS*NCOLS-1:0] pressed = '0;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         pulses  = 0;
   logic [3:0] obs_q[$];
   int         exp_hist[NDIG];

   always #5 clk = ~clk;

   keypad_history_display #(
      .NROWS(NROWS), .NCOLS(NCOLS), .NDIG(NDIG), .SCAN_DIV(SCAN_DIV),
      .DB_TICKS(DB_TICKS), .MUX_DIV(MUX_DIV), .CLEAR_EN(CLEAR_EN),
      .CLEAR_CODE(CLEAR_CODE)
   ) dut (
      .clk(clk), .reset(reset), .cols(cols), .rows(rows), .seg(seg),
      .anode(anode), .key_valid(key_valid), .key_code(key_code)
   );

   // Physical keypad: a pressed switch shorts its column to its row line.
   always_comb begin
      cols = '1;
      for (int r = 0; r < NROWS; r++)
         for (int c = 0; c < NCOLS; c++)
            if (pressed[r*NCOLS+c] && !rows[r]) cols[c] = 1'b0;
   end

   always @(negedge clk) begin
      if (key_valid) begin
         pulses = pulses + 1;
         obs_q.push_back(key_code);
      end
   end

   // ---------------- reference model ----------------
   function automatic int label_code(int r, int c);
      string keys;
      int    ch;
      keys = "123A456B789C*0#D";
      ch = int'(keys[r*4+c]);
      if (ch >= 48 && ch <= 57) return ch - 48;
      if (ch >= 65 && ch <= 68) return ch - 65 + 10;
      if (ch == 42) return 14;
      return 15;
   endfunction

   function automatic logic [6:0] glyph(int v);
      string s;
      logic [6:0] g;
      case (v)
         0: s = "abcdef";  1: s = "bc";      2: s = "abdeg";   3: s = "abcdg";
         4: s = "bcfg";    5: s = "acdfg";   6: s = "acdefg";  7: s = "abc";
         8: s = "abcdefg"; 9: s = "abcdfg";  10: s = "abcefg"; 11: s = "cdefg";
         12: s = "adef";   13: s = "bcdeg";  14: s = "adefg";  default: s = "aefg";
      endcase
      g = 7'h7F;
      for (int i = 0; i < s.len(); i++) g[int'(s[i]) - 97] = 1'b0;
      return g;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NDIG; i++) exp_hist[i] = 0;
   endfunction

   function automatic void model_accept(int code);
      if (CLEAR_EN != 0 && code == int'(CLEAR_CODE)) begin
         model_reset();
      end else begin
         for (int i = NDIG-1; i > 0; i--) exp_hist[i] = exp_hist[i-1];
         exp_hist[0] = code;
      end
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic wait_clk(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic hit(int r, int c, int hold_ticks, int gap_ticks);
      pressed[r*NCOLS+c] = 1'b1;
      wait_clk(hold_ticks * SCAN_DIV);
      pressed[r*NCOLS+c] = 1'b0;
      wait_clk(gap_ticks * SCAN_DIV);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      wait_clk(3);
      n_tests++; if (rows !== 4'b1110) begin n_fail++; $display("FAIL reset_rows got %b want 1110", rows); end
      n_tests++; if (anode !== 2'b11) begin n_fail++; $display("FAIL reset_anode got %b want 11", anode); end
      n_tests++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got %h want 7f", seg); end
      n_tests++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid got %b want 0", key_valid); end
      n_tests++; if (key_code !== 4'h0) begin n_fail++; $display("FAIL reset_key_code got %h want 0", key_code); end
      model_reset();
      reset = 1'b1;
      wait_clk(2);
   endtask

   task automatic test_display(string name);
      logic            seen[NDIG];
      logic [NDIG-1:0] prev;
      int              run, changes, bad, idx, nseen;
      for (int i = 0; i < NDIG; i++) seen[i] = 1'b0;
      prev = anode; run = 0; changes = 0; bad = 0;
      for (int k = 0; k < 3*NDIG*MUX_DIV; k++) begin
         @(negedge clk);
         if ($countones(~anode) != 1) begin
            bad++;
         end else begin
            idx = 0;
            for (int i = 0; i < NDIG; i++) if (!anode[i]) idx = i;
            if (!seen[idx]) begin
               seen[idx] = 1'b1;
               n_tests++;
               if (seg !== glyph(exp_hist[idx])) begin
                  n_fail++;
                  $display("FAIL %s_digit%0d_seg got %h want %h", name, idx, seg, glyph(exp_hist[idx]));
               end
            end
         end
         if (anode !== prev) begin
            if (changes > 0) begin
               n_tests++;
               if (run != MUX_DIV) begin
                  n_fail++;
                  $display("FAIL %s_slot_len got %0d want %0d", name, run, MUX_DIV);
               end
            end
            changes++; run = 1; prev = anode;
         end else begin
            run++;
         end
      end
      nseen = 0;
      for (int i = 0; i < NDIG; i++) if (seen[i]) nseen++;
      n_tests++;
      if (bad != 0 || nseen != NDIG) begin
         n_fail++;
         $display("FAIL %s_anode_scan bad_samples %0d digits_seen %0d want 0 and %0d", name, bad, nseen, NDIG);
      end
      wait_clk(1);
   endtask

   task automatic test_single_press();
      int p0;
      p0 = pulses;
      hit(1, 2, 20, 10);
      n_tests++; if (pulses - p0 != 1) begin n_fail++; $display("FAIL single_pulses got %0d want 1", pulses - p0); end
      n_tests++; if (key_code !== 4'h6) begin n_fail++; $display("FAIL single_code got %h want 6", key_code); end
      model_accept(6);
      test_display("single");
   endtask

   task automatic test_sequence();
      int p0;
      p0 = pulses;
      hit(0, 0, 14, 8);
      hit(0, 1, 14, 8);
      hit(0, 2, 14, 8);
      n_tests++; if (pulses - p0 != 3) begin n_fail++; $display("FAIL seq_pulses got %0d want 3", pulses - p0); end
      n_tests++; if (key_code !== 4'h3) begin n_fail++; $display("FAIL seq_code got %h want 3", key_code); end
      model_accept(1); model_accept(2); model_accept(3);
      test_display("seq");
   endtask

   task automatic test_bounce();
      int p0;
      p0 = pulses;
      pressed[3*NCOLS+1] = 1'b1;
      wait_clk(2*SCAN_DIV);
      pressed[3*NCOLS+1] = 1'b0;
      wait_clk(1*SCAN_DIV);
      n_tests++; if (pulses - p0 != 0) begin n_fail++; $display("FAIL bounce_early got %0d pulses want 0", pulses - p0); end
      hit(3, 1, 12, 10);
      n_tests++; if (pulses - p0 != 1) begin n_fail++; $display("FAIL bounce_pulses got %0d want 1", pulses - p0); end
      n_tests++; if (key_code !== 4'h0) begin n_fail++; $display("FAIL bounce_code got %h want 0", key_code); end
      model_accept(0);
   endtask

   task automatic test_concurrent();
      int p0;
      p0 = pulses;
      pressed[1*NCOLS+1] = 1'b1;
      wait_clk(12*SCAN_DIV);
      pressed[2*NCOLS+2] = 1'b1;
      wait_clk(10*SCAN_DIV);
      n_tests++; if (pulses - p0 != 1) begin n_fail++; $display("FAIL conc_held got %0d pulses want 1", pulses - p0); end
      n_tests++; if (key_code !== 4'h5) begin n_fail++; $display("FAIL conc_code5 got %h want 5", key_code); end
      pressed[1*NCOLS+1] = 1'b0;
      wait_clk(1*SCAN_DIV);
      pressed[2*NCOLS+2] = 1'b0;
      wait_clk(10*SCAN_DIV);
      n_tests++; if (pulses - p0 != 1) begin n_fail++; $display("FAIL conc_release got %0d pulses want 1", pulses - p0); end
      hit(2, 2, 14, 8);
      n_tests++; if (pulses - p0 != 2) begin n_fail++; $display("FAIL conc_repress got %0d pulses want 2", pulses - p0); end
      n_tests++; if (key_code !== 4'h9) begin n_fail++; $display("FAIL conc_code9 got %h want 9", key_code); end
      model_accept(5); model_accept(9);
      test_display("conc");
   endtask

   task automatic test_clear();
      int p0;
      p0 = pulses;
      hit(1, 0, 14, 8);
      hit(2, 0, 14, 8);
      hit(3, 0, 14, 8);
      n_tests++; if (pulses - p0 != 3) begin n_fail++; $display("FAIL clear_pulses got %0d want 3", pulses - p0); end
      n_tests++; if (key_code !== 4'hE) begin n_fail++; $display("FAIL clear_code got %h want e", key_code); end
      model_accept(4); model_accept(7); model_accept(14);
      test_display("clear");
   endtask

   task automatic test_reset_mid();
      int p0;
      reset = 1'b0;
      wait_clk(3);
      reset = 1'b1;
      model_reset();
      p0 = pulses;
      pressed[0] = 1'b1;
      wait_clk(9);
      n_tests++; if (pulses - p0 != 0) begin n_fail++; $display("FAIL rmid_pre got %0d pulses want 0", pulses - p0); end
      #2;
      reset = 1'b0;
      #1;
      n_tests++; if (rows !== 4'b1110) begin n_fail++; $display("FAIL rmid_rows got %b want 1110", rows); end
      n_tests++; if (anode !== 2'b11) begin n_fail++; $display("FAIL rmid_anode got %b want 11", anode); end
      n_tests++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL rmid_seg got %h want 7f", seg); end
      n_tests++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_key_valid got %b want 0", key_valid); end
      wait_clk(4);
      n_tests++; if (pulses - p0 != 0) begin n_fail++; $display("FAIL rmid_during got %0d pulses want 0", pulses - p0); end
      reset = 1'b1;
      wait_clk(12*SCAN_DIV);
      pressed[0] = 1'b0;
      wait_clk(8*SCAN_DIV);
      n_tests++; if (pulses - p0 != 1) begin n_fail++; $display("FAIL rmid_after got %0d pulses want 1", pulses - p0); end
      n_tests++; if (key_code !== 4'h1) begin n_fail++; $display("FAIL rmid_code got %h want 1", key_code); end
      model_accept(1);
      test_display("rmid");
   endtask

   task automatic test_random();
      int exp_q[$];
      int r, c, code;
      obs_q.delete();
      for (int n = 0; n < 10; n++) begin
         r = $urandom_range(0, NROWS-1);
         c = $urandom_range(0, NCOLS-1);
         code = label_code(r, c);
         exp_q.push_back(code);
         model_accept(code);
         hit(r, c, $urandom_range(12, 16), $urandom_range(6, 9));
      end
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (int'(obs_q[i]) != exp_q[i]) begin
               n_fail++;
               $display("FAIL rand_code%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
         end
      end
      test_display("rand");
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_sequence();
      test_bounce();
      test_concurrent();
      test_clear();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/keypad_history_display.md
KEYPAD_HISTORY_DISPLAY -- requirements
Module: keypad_history_display

Interface
REQ-001 SHALL have parameter NROWS, default 4, keypad row count (2..8).
REQ-002 SHALL have parameter NCOLS, default 4, keypad column count (2..8).
REQ-003 SHALL have parameter NDIG, default 2, number of displayed history digits (1..8).
REQ-004 SHALL have parameter SCAN_DIV, default 60000, clk cycles per scan tick.
REQ-005 SHALL have parameter DB_TICKS, default 4, consecutive stable ticks for press/release debounce (>=1).
REQ-006 SHALL have parameter MUX_DIV, default 30000, clk cycles per display digit slot.
REQ-007 SHALL have parameter CLEAR_EN, default 0, enables clear-key mode.
REQ-008 SHALL have parameter CLEAR_CODE, default 4'hE, key code that clears history when CLEAR_EN=1.
REQ-009 SHALL have port: clk  input  1  system clock.
REQ-010 SHALL have port: reset  input  1  reset, asynchronous, active-low.
REQ-011 SHALL have port: cols  input  NCOLS  keypad columns, active-low, pulled up, asynchronous.
REQ-012 SHALL have port: rows  output  NROWS  row drive, one-cold, active-low.
REQ-013 SHALL have port: seg  output  7  segments a..g, active-low.
REQ-014 SHALL have port: anode  output  NDIG  digit enables, one-cold, active-low.
REQ-015 SHALL have port: key_valid  output  1  one-clk pulse per accepted press.
REQ-016 SHALL have port: key_code  output  4  code of last accepted key, held between pulses.

Function
REQ-017 SHALL synchronise cols through two flops before any use; scan decisions lag the pins by 2 clk.
REQ-018 SHALL generate tick every SCAN_DIV clk: counter 0..SCAN_DIV-1, wraps, tick on wrap.
REQ-019 SHALL use FSM states SCAN, DEBOUNCE, HELD, REL_DB; all transitions occur only on tick.
REQ-020 SCAN: SHALL drive row r low; if any synced col low, latch (r, lowest-index low col), cnt=0, go DEBOUNCE; else r advances, NROWS-1 wraps to 0.
REQ-021 DEBOUNCE: row held; latched col low -> cnt++; on cnt reaching DB_TICKS, SHALL pulse key_valid one clk, update key_code, go HELD; latched col high -> SCAN, no pulse.
REQ-022 HELD: row held; SHALL ignore all other keys; latched col high -> REL_DB, cnt=0.
REQ-023 REL_DB: latched col high for DB_TICKS ticks -> SCAN at next row; low again -> HELD, no new pulse (no auto-repeat).
REQ-024 Key code SHALL come from the 4x4 KEYMAP table when NROWS=NCOLS=4, else (row*NCOLS+col) mod 16.
REQ-025 On key_valid, history SHALL shift: hist[0]<=code, hist[i]<=hist[i-1]; hist[NDIG-1] discarded.
REQ-026 With CLEAR_EN=1 and code==CLEAR_CODE, SHALL zero all hist instead of shifting; key_valid still pulses.
REQ-027 Digit index SHALL advance every MUX_DIV clk, NDIG-1 wraps to 0; anode[idx]=0, seg=decode(hist[idx]).
REQ-028 seg and anode SHALL be registered and change on the same clk edge (no ghosting).
REQ-029 Hex decode SHALL display 0..F conventional glyphs (b, d lower-case).

Reset
REQ-030 On reset low, SHALL immediately: state SCAN, r=0, rows=~1, all counters 0, hist all 0.
REQ-031 Reset outputs: key_valid=0, key_code=0, anode all 1, seg=7'h7F.
REQ-032 Reset mid-press SHALL abandon it with no pulse; press still held after release of reset is re-debounced from SCAN.

Structure
REQ-033 Package keypad_pkg SHALL hold the state enum, the 4x4 KEYMAP constant and the 16-entry segment table.
REQ-034 SHALL instantiate one sub-module hex7seg (4-bit in, 7-bit active-low out); all else inline.

Verification (SCAN_DIV=4, MUX_DIV=8, DB_TICKS=3)
REQ-035 Press row1/col2 (code 6) held 20 ticks -> exactly one key_valid, key_code=6, hist[0]=6.
REQ-036 Presses 1,2,3 (NDIG=2) -> hist={3,2}; anode alternates 2'b10/2'b01 every 8 clk with seg of 3 then 2.
REQ-037 Bounce: col low 2 ticks, high 1, low 3 -> one pulse only, after the final 3 stable ticks.
REQ-038 Hold key 5 then press key 9 concurrently, release 5 then 9 -> one pulse for 5, none for 9 until 9 released and re-pressed.
REQ-039 CLEAR_EN=1: enter 4,7 then CLEAR_CODE -> hist all 0, key_valid pulsed, key_code=4'hE.
REQ-040 Assert reset during DEBOUNCE -> outputs at reset values within 0 clk, no pulse, scan restarts at row 0.
